// File: rtl/mem_bus_arbiter.sv
// Arbitrates the core's single memory port between instruction fetch and load/store.
// Runs one transaction at a time and ends each with a one-cycle Ack, or an Err on misalignment or timeout.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter bit          ROUND_ROBIN    = 1'b0
) (
   input  logic        CoreClock,
   input  logic        CoreResetN,
   input  logic        FetchReq,
   input  logic [31:0] FetchAddr,
   output logic        FetchAck,
   output logic        FetchErr,
   output logic [31:0] FetchRData,
   input  logic        DataReq,
   input  logic        DataWrite,
   input  logic [31:0] DataAddr,
   input  logic [31:0] DataWData,
   output logic        DataAck,
   output logic        DataErr,
   output logic [31:0] DataRData,
   output logic [31:0] MemAddress,
   output logic [31:0] MemWriteData,
   output logic        MemReadAssert,
   output logic        MemWriteAssert,
   input  logic [31:0] MemReadData,
   input  logic        MemReadOK,
   input  logic        MemWriteOK
);

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } arbState_t;

   arbState_t   state;
   arbState_t   nextState;

   logic        grantData;
   logic        isWrite;
   logic        errFlag;
   logic        preferFetch;
   logic [7:0]  timeoutCount;
   logic [31:0] readLatch;

   logic        anyReq;
   logic        pickData;
   logic        pickWrite;
   logic [31:0] pickAddr;
   logic        misaligned;
   logic        memOk;
   logic        timedOut;

   // Grant selection: under contention Data wins, unless round-robin hands it to the port not served last.
   always_comb begin
      // NOTE: every signal driven here gets a value before any branch, so no path can infer a latch.
      anyReq     = FetchReq | DataReq;
      pickData   = DataReq && (!FetchReq || !ROUND_ROBIN || !preferFetch);
      pickWrite  = pickData && DataWrite;
      pickAddr   = pickData ? DataAddr : FetchAddr;
      misaligned = (pickAddr[1:0] != 2'b00);
      memOk      = isWrite ? MemWriteOK : MemReadOK;
      timedOut   = (timeoutCount == 8'(TIMEOUT_CYCLES - 1));
   end

   always_comb begin
      nextState = state;
      case (state)
         StIdle:  if (anyReq) nextState = misaligned ? StDone : StBusy;
         StBusy:  if (memOk || timedOut) nextState = StDone;
         StDone:  nextState = StIdle;
         default: nextState = StIdle;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop updates from the same pre-edge values.
   always_ff @(posedge CoreClock or negedge CoreResetN) begin
      if (!CoreResetN) state <= StIdle;
      else             state <= nextState;
   end

   always_ff @(posedge CoreClock or negedge CoreResetN) begin
      if (!CoreResetN) begin
         grantData      <= 1'b0;
         isWrite        <= 1'b0;
         errFlag        <= 1'b0;
         preferFetch    <= 1'b1;
         timeoutCount   <= '0;
         readLatch      <= '0;
         FetchAck       <= 1'b0;
         FetchErr       <= 1'b0;
         FetchRData     <= '0;
         DataAck        <= 1'b0;
         DataErr        <= 1'b0;
         DataRData      <= '0;
         MemAddress     <= '0;
         MemWriteData   <= '0;
         MemReadAssert  <= 1'b0;
         MemWriteAssert <= 1'b0;
      end else begin
         FetchAck   <= 1'b0;
         FetchErr   <= 1'b0;
         FetchRData <= '0;
         DataAck    <= 1'b0;
         DataErr    <= 1'b0;
         DataRData  <= '0;

         case (state)
            StIdle: begin
               if (anyReq) begin
                  grantData      <= pickData;
                  isWrite        <= pickWrite;
                  errFlag        <= misaligned;
                  preferFetch    <= pickData;
                  timeoutCount   <= '0;
                  readLatch      <= '0;
                  MemAddress     <= {2'b00, pickAddr[31:2]};
                  MemWriteData   <= pickWrite ? DataWData : '0;
                  MemReadAssert  <= !misaligned && !pickWrite;
                  MemWriteAssert <= !misaligned && pickWrite;
               end
            end

            StBusy: begin
               if (memOk) begin
                  errFlag        <= 1'b0;
                  if (!isWrite) readLatch <= MemReadData;
                  MemReadAssert  <= 1'b0;
                  MemWriteAssert <= 1'b0;
               end else if (timedOut) begin
                  errFlag        <= 1'b1;
                  MemReadAssert  <= 1'b0;
                  MemWriteAssert <= 1'b0;
               end else begin
                  timeoutCount   <= timeoutCount + 8'd1;
               end
            end

            StDone: begin
               // readLatch stays zero for stores, so only a successful read returns data.
               FetchAck   <= !grantData;
               FetchErr   <= !grantData && errFlag;
               FetchRData <= (!grantData && !errFlag) ? readLatch : '0;
               DataAck    <= grantData;
               DataErr    <= grantData && errFlag;
               DataRData  <= (grantData && !errFlag) ? readLatch : '0;
            end

            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a fixed-priority and a round-robin instance share stimulus,
// a queue holds the expected Ack records, and a memory responder answers after a set delay.
module tb_mem_bus_arbiter;

   logic        CoreClock;
   logic        CoreResetN;
   logic        FetchReq;
   logic [31:0] FetchAddr;
   logic        DataReq;
   logic        DataWrite;
   logic [31:0] DataAddr;
   logic [31:0] DataWData;
   logic [31:0] MemReadData;
   logic        MemReadOK;
   logic        MemWriteOK;

   logic        fetchAck     [2];
   logic        fetchErr     [2];
   logic [31:0] fetchRData   [2];
   logic        dataAck      [2];
   logic        dataErr      [2];
   logic [31:0] dataRData    [2];
   logic [31:0] memAddress   [2];
   logic [31:0] memWriteData [2];
   logic        memRead      [2];
   logic        memWrite     [2];

   typedef struct {
      bit          isData;
      bit          err;
      logic [31:0] rdata;
   } expT;

   expT sbq[$];

   int testsRun    = 0;
   int testsFailed = 0;

   // Responder controls: which instance it serves, OK delay in BUSY cycles (-1 = never), stray OK.
   int sel       = 0;
   int respDelay = -1;
   bit wrongOk   = 1'b0;
   int busyCnt   = 0;
   int rdCnt     = 0;
   int wrCnt     = 0;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(16), .ROUND_ROBIN(1'b0)) u_dutFixed (
      .CoreClock(CoreClock), .CoreResetN(CoreResetN),
      .FetchReq(FetchReq), .FetchAddr(FetchAddr),
      .FetchAck(fetchAck[0]), .FetchErr(fetchErr[0]), .FetchRData(fetchRData[0]),
      .DataReq(DataReq), .DataWrite(DataWrite), .DataAddr(DataAddr), .DataWData(DataWData),
      .DataAck(dataAck[0]), .DataErr(dataErr[0]), .DataRData(dataRData[0]),
      .MemAddress(memAddress[0]), .MemWriteData(memWriteData[0]),
      .MemReadAssert(memRead[0]), .MemWriteAssert(memWrite[0]),
      .MemReadData(MemReadData), .MemReadOK(MemReadOK), .MemWriteOK(MemWriteOK)
   );

   mem_bus_arbiter #(.TIMEOUT_CYCLES(16), .ROUND_ROBIN(1'b1)) u_dutRr (
      .CoreClock(CoreClock), .CoreResetN(CoreResetN),
      .FetchReq(FetchReq), .FetchAddr(FetchAddr),
      .FetchAck(fetchAck[1]), .FetchErr(fetchErr[1]), .FetchRData(fetchRData[1]),
      .DataReq(DataReq), .DataWrite(DataWrite), .DataAddr(DataAddr), .DataWData(DataWData),
      .DataAck(dataAck[1]), .DataErr(dataErr[1]), .DataRData(dataRData[1]),
      .MemAddress(memAddress[1]), .MemWriteData(memWriteData[1]),
      .MemReadAssert(memRead[1]), .MemWriteAssert(memWrite[1]),
      .MemReadData(MemReadData), .MemReadOK(MemReadOK), .MemWriteOK(MemWriteOK)
   );

   initial CoreClock = 1'b0;
   always #5 CoreClock = ~CoreClock;

   always @(negedge CoreClock) begin
      if (memRead[sel] || memWrite[sel]) begin
         MemReadOK  = memRead[sel] && (busyCnt == respDelay);
         MemWriteOK = (memWrite[sel] && (busyCnt == respDelay)) || (wrongOk && memRead[sel]);
         busyCnt++;
         rdCnt += int'(memRead[sel]);
         wrCnt += int'(memWrite[sel]);
      end else begin
         MemReadOK  = 1'b0;
         MemWriteOK = 1'b0;
         busyCnt    = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic pushExp(input bit isData, input bit err, input logic [31:0] rdata);
      expT e;
      e.isData = isData;
      e.err    = err;
      e.rdata  = rdata;
      sbq.push_back(e);
   endtask

   task automatic checkQuiet(input int d, input string tag);
      check({tag, "_ctrl"}, {26'd0, fetchAck[d], fetchErr[d], dataAck[d], dataErr[d], memRead[d], memWrite[d]}, 32'd0);
      check({tag, "_data"}, fetchRData[d] | dataRData[d] | memAddress[d] | memWriteData[d], 32'd0);
   endtask

   // Waits for the next Ack on instance d, pops the oldest expectation and compares against it.
   task automatic waitAck(input string tag, input int d, input int expEdges, input bit dropReq);
      int  edges = 0;
      bit  seen  = 1'b0;
      expT e;
      while (!seen && edges < 200) begin
         @(negedge CoreClock);
         edges++;
         seen = fetchAck[d] | dataAck[d];
      end
      check({tag, "_ack_seen"}, 32'(seen), 32'd1);
      if (!seen) return;
      check({tag, "_sb_has_entry"}, 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() == 0) return;
      e = sbq.pop_front();
      check({tag, "_port"}, 32'(dataAck[d]), 32'(e.isData));
      check({tag, "_dual_ack"}, 32'(fetchAck[d] & dataAck[d]), 32'd0);
      check({tag, "_err"}, 32'(e.isData ? dataErr[d] : fetchErr[d]), 32'(e.err));
      check({tag, "_rdata"}, e.isData ? dataRData[d] : fetchRData[d], e.rdata);
      check({tag, "_other_port"},
            e.isData ? (fetchRData[d] | 32'(fetchErr[d])) : (dataRData[d] | 32'(dataErr[d])), 32'd0);
      check({tag, "_latency"}, 32'(edges), 32'(expEdges));
      if (dropReq) begin
         if (dataAck[d]) DataReq = 1'b0;
         else            FetchReq = 1'b0;
      end
   endtask

   initial begin
      CoreResetN  = 1'b0;
      FetchReq    = 1'b0;
      FetchAddr   = '0;
      DataReq     = 1'b0;
      DataWrite   = 1'b0;
      DataAddr    = '0;
      DataWData   = '0;
      MemReadData = '0;
      MemReadOK   = 1'b0;
      MemWriteOK  = 1'b0;

      repeat (2) @(negedge CoreClock);
      checkQuiet(0, "reset_fixed");
      checkQuiet(1, "reset_rr");
      CoreResetN = 1'b1;
      @(negedge CoreClock);
      checkQuiet(0, "idle_fixed");

      // Fetch read answered on the first BUSY cycle.
      MemReadData = 32'hDEAD_BEEF;
      respDelay   = 0;
      rdCnt       = 0;
      wrCnt       = 0;
      FetchAddr   = 32'h0000_0010;
      FetchReq    = 1'b1;
      pushExp(1'b0, 1'b0, 32'hDEAD_BEEF);
      waitAck("t1", 0, 3, 1'b1);
      check("t1_mem_addr", memAddress[0], 32'h0000_0004);
      check("t1_read_cycles", 32'(rdCnt), 32'd1);
      @(negedge CoreClock);
      check("t1_ack_pulse", 32'(fetchAck[0]), 32'd0);
      check("t1_strobes_idle", {30'd0, memRead[0], memWrite[0]}, 32'd0);

      // Store answered after four waiting cycles.
      rdCnt     = 0;
      wrCnt     = 0;
      respDelay = 4;
      DataAddr  = 32'h0000_0100;
      DataWData = 32'h1234_5678;
      DataWrite = 1'b1;
      DataReq   = 1'b1;
      pushExp(1'b1, 1'b0, 32'h0);
      waitAck("t2", 0, 7, 1'b1);
      check("t2_write_cycles", 32'(wrCnt), 32'd5);
      check("t2_read_cycles", 32'(rdCnt), 32'd0);
      check("t2_wdata", memWriteData[0], 32'h1234_5678);
      check("t2_mem_addr", memAddress[0], 32'h0000_0040);
      DataWrite = 1'b0;

      // Load that memory never answers; a stray write OK must not complete it.
      rdCnt       = 0;
      respDelay   = -1;
      wrongOk     = 1'b1;
      MemReadData = 32'h5555_AAAA;
      DataAddr    = 32'h0000_0200;
      DataReq     = 1'b1;
      pushExp(1'b1, 1'b1, 32'h0);
      waitAck("t4", 0, 18, 1'b1);
      check("t4_read_cycles", 32'(rdCnt), 32'd16);
      wrongOk = 1'b0;

      respDelay   = 1;
      MemReadData = 32'hCAFE_F00D;
      FetchAddr   = 32'h0000_0300;
      FetchReq    = 1'b1;
      pushExp(1'b0, 1'b0, 32'hCAFE_F00D);
      waitAck("t4_next", 0, 4, 1'b1);
      check("t4_next_mem_addr", memAddress[0], 32'h0000_00C0);

      // Misaligned fetch errors out without touching the bus.
      rdCnt     = 0;
      wrCnt     = 0;
      FetchAddr = 32'h0000_0006;
      FetchReq  = 1'b1;
      pushExp(1'b0, 1'b1, 32'h0);
      waitAck("t5", 0, 2, 1'b1);
      check("t5_strobe_cycles", 32'(rdCnt + wrCnt), 32'd0);

      // Simultaneous requests on the fixed-priority instance: Data first, then Fetch.
      respDelay   = 0;
      MemReadData = 32'h1111_2222;
      FetchAddr   = 32'h0000_0020;
      DataAddr    = 32'h0000_0040;
      FetchReq    = 1'b1;
      DataReq     = 1'b1;
      pushExp(1'b1, 1'b0, 32'h1111_2222);
      pushExp(1'b0, 1'b0, 32'h1111_2222);
      waitAck("t3_fixed_first", 0, 3, 1'b1);
      waitAck("t3_fixed_second", 0, 3, 1'b1);
      check("t3_fixed_mem_addr", memAddress[0], 32'h0000_0008);

      // Asynchronous reset while a load waits in BUSY; the held request restarts afterwards.
      respDelay   = -1;
      MemReadData = 32'h7777_0001;
      DataAddr    = 32'h0000_0044;
      DataReq     = 1'b1;
      pushExp(1'b1, 1'b0, 32'h7777_0001);
      repeat (3) @(negedge CoreClock);
      check("t6_busy", 32'(memRead[0]), 32'd1);
      #2 CoreResetN = 1'b0;
      #1 checkQuiet(0, "t6_async_fixed");
      checkQuiet(1, "t6_async_rr");
      repeat (2) begin
         @(negedge CoreClock);
         checkQuiet(0, "t6_held");
      end
      respDelay  = 0;
      CoreResetN = 1'b1;
      waitAck("t6_restart", 0, 3, 1'b1);

      // Round-robin instance with both ports held: Fetch, Data, Fetch, Data.
      @(negedge CoreClock);
      CoreResetN = 1'b0;
      @(negedge CoreClock);
      CoreResetN  = 1'b1;
      sel         = 1;
      respDelay   = 0;
      MemReadData = 32'h0F0F_0F0F;
      FetchAddr   = 32'h0000_0080;
      DataAddr    = 32'h0000_0084;
      DataWrite   = 1'b0;
      FetchReq    = 1'b1;
      DataReq     = 1'b1;
      for (int i = 0; i < 4; i++) pushExp(i[0], 1'b0, 32'h0F0F_0F0F);
      for (int i = 0; i < 4; i++) waitAck($sformatf("t3_rr%0d", i), 1, 3, 1'b0);
      FetchReq = 1'b0;
      DataReq  = 1'b0;

      repeat (2) @(negedge CoreClock);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
